// File: rtl/uart_rx_byte_fifo.sv
// uart_rx_byte_fifo: show-ahead byte FIFO behind a UART receiver, pushing on each rx_done rising edge.
// Define UART_RX_FIFO_ERR_TAG_EN to store rx_error alongside each byte.
module uart_rx_byte_fifo #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     rx_done,
    input  logic [DATA_BITS-1:0]     rx_data,
    input  logic                     rx_error,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_BITS-1:0]     out_data,
    output logic                     out_error,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    input  logic                     ovf_clr
);
    localparam int ADDR_W = $clog2(DEPTH);
`ifdef UART_RX_FIFO_ERR_TAG_EN
    localparam int MEM_W = DATA_BITS + 1;
`else
    localparam int MEM_W = DATA_BITS;
`endif
    logic [MEM_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_q, wr_d, rd_q, rd_d;
    logic             rx_done_q, overflow_q, overflow_d;
    logic             push_evt, pop, push_ok, drop;
    logic [MEM_W-1:0] wdata, head;

    assign out_valid = wr_q != rd_q;
    assign count     = wr_q - rd_q;
    assign full      = (wr_q[ADDR_W-1:0] == rd_q[ADDR_W-1:0]) && (wr_q[ADDR_W] != rd_q[ADDR_W]);
    assign overflow  = overflow_q;
    assign head      = mem[rd_q[ADDR_W-1:0]];
    assign out_data  = out_valid ? head[DATA_BITS-1:0] : '0;
`ifdef UART_RX_FIFO_ERR_TAG_EN
    assign wdata     = {rx_error, rx_data};
    assign out_error = out_valid & head[DATA_BITS];
`else
    logic unused_rx_error;
    assign unused_rx_error = rx_error;
    assign wdata     = rx_data;
    assign out_error = 1'b0;
`endif

    // A push into a full FIFO survives only if the head leaves the same cycle; flush discards it outright.
    always_comb begin
        push_evt   = rx_done & ~rx_done_q;
        pop        = out_valid & out_ready;
        push_ok    = push_evt & (~full | pop) & ~flush;
        drop       = push_evt & full & ~pop & ~flush;
        wr_d       = flush ? '0 : wr_q + (ADDR_W+1)'(push_ok);
        rd_d       = flush ? '0 : rd_q + (ADDR_W+1)'(pop);
        overflow_d = drop | (overflow_q & ~ovf_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            rx_done_q  <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            rx_done_q  <= rx_done;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk)
        if (push_ok) mem[wr_q[ADDR_W-1:0]] <= wdata;
endmodule

// File: tb/tb_uart_rx_byte_fifo.sv
// tb_uart_rx_byte_fifo: directed and randomized checks against a queue-based reference model.
module tb_uart_rx_byte_fifo;
    localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_ERR_TAG_EN
    localparam bit TAG = 1'b1;
`else
    localparam bit TAG = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst_n, rx_done, rx_error, flush, out_ready, ovf_clr;
    logic [7:0] rx_data;
    logic       out_valid, out_error, full, overflow;
    logic [7:0] out_data;
    logic [4:0] count;
    int checks = 0, errors = 0;

    uart_rx_byte_fifo dut (
        .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_data(rx_data), .rx_error(rx_error),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_error(out_error), .count(count), .full(full), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of {error, data} entries updated with the FIFO's rules each edge.
    logic [8:0] q[$];
    bit m_ovf, m_prev;
    always @(posedge clk or negedge rst_n) begin
        bit ev, pp, drop;
        int n;
        if (!rst_n) begin
            q.delete();
            m_ovf = 1'b0;
            m_prev = 1'b1;
        end else begin
            n = q.size();
            ev = rx_done && !m_prev;
            pp = n > 0 && out_ready;
            drop = 1'b0;
            if (flush) q.delete();
            else begin
                if (pp) void'(q.pop_front());
                if (ev) begin
                    if (n < DEPTH || pp) q.push_back({rx_error && TAG, rx_data});
                    else drop = 1'b1;
                end
            end
            m_ovf = drop || (m_ovf && !ovf_clr);
            m_prev = rx_done;
        end
    end

    task automatic push_byte(input logic [7:0] d, input logic e);
        @(negedge clk) rx_done = 1'b0;
        @(negedge clk) begin rx_done = 1'b1; rx_data = d; rx_error = e; end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; rx_done = 1'b1; rx_data = '0; rx_error = 1'b0;
        flush = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({out_valid, count, full, overflow, out_data, out_error} !== 17'd0) begin
            errors++;
            $display("FAIL reset_values got v=%0b cnt=%0d full=%0b ovf=%0b data=%h err=%0b want all 0",
                     out_valid, count, full, overflow, out_data, out_error);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (count !== 5'd0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle_high cyc %0d got cnt=%0d v=%0b want 0 0", i, count, out_valid);
            end
        end
    endtask

    task automatic test_basic;
        logic [7:0] exp [3] = '{8'h41, 8'h42, 8'h43};
        for (int i = 0; i < 3; i++) push_byte(exp[i], 1'b0);
        @(negedge clk);
        checks++;
        if (count !== 5'd3 || out_valid !== 1'b1 || out_data !== 8'h41) begin
            errors++;
            $display("FAIL basic_fill got cnt=%0d v=%0b head=%h want 3 1 41", count, out_valid, out_data);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                errors++;
                $display("FAIL basic_drain %0d got v=%0b data=%h want 1 %h", i, out_valid, out_data, exp[i]);
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("FAIL basic_empty got v=%0b cnt=%0d want 0 0", out_valid, count);
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0);
        push_byte(8'hAA, 1'b0);
        @(negedge clk);
        checks++;
        if (full !== 1'b1 || overflow !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("FAIL ovf_full got full=%0b ovf=%0b cnt=%0d want 1 1 16", full, overflow, count);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'(i)) begin
                errors++;
                $display("FAIL ovf_drain %0d got v=%0b data=%h want 1 %h", i, out_valid, out_data, 8'(i));
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_dropped got v=%0b ovf=%0b want 0 1", out_valid, overflow);
        end
        ovf_clr = 1'b1;
        @(negedge clk) ovf_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr got ovf=%0b want 0", overflow);
        end
    endtask

    task automatic test_full_push_pop;
        for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0);
        @(negedge clk) rx_done = 1'b0;
        @(negedge clk) begin rx_done = 1'b1; rx_data = 8'h55; out_ready = 1'b1; end
        @(negedge clk) out_ready = 1'b0;
        checks++;
        if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin
            errors++;
            $display("FAIL fpp_state got cnt=%0d ovf=%0b full=%0b want 16 0 1", count, overflow, full);
        end
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            checks++;
            if (out_data !== (i == 16 ? 8'h55 : 8'(i))) begin
                errors++;
                $display("FAIL fpp_drain %0d got %h want %h", i, out_data, (i == 16 ? 8'h55 : 8'(i)));
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_hold_flush;
        push_byte(8'h77, 1'b0);
        repeat (100) @(negedge clk);
        checks++;
        if (count !== 5'd1 || out_data !== 8'h77) begin
            errors++;
            $display("FAIL hold_one got cnt=%0d data=%h want 1 77", count, out_data);
        end
        rx_done = 1'b0;
        @(negedge clk) begin rx_done = 1'b1; rx_data = 8'h66; flush = 1'b1; end
        @(negedge clk) flush = 1'b0;
        checks++;
        if (count !== 5'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_edge got cnt=%0d v=%0b want 0 0", count, out_valid);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (count !== 5'd0) begin
            errors++;
            $display("FAIL flush_no_replay got cnt=%0d want 0", count);
        end
    endtask

    task automatic test_err_tag;
        push_byte(8'h10, 1'b1);
        push_byte(8'h11, 1'b0);
        @(negedge clk);
        checks++;
        if (out_data !== 8'h10 || out_error !== TAG) begin
            errors++;
            $display("FAIL err_tag_first got data=%h err=%0b want 10 %0b", out_data, out_error, TAG);
        end
        out_ready = 1'b1;
        @(negedge clk) out_ready = 1'b0;
        checks++;
        if (out_data !== 8'h11 || out_error !== 1'b0) begin
            errors++;
            $display("FAIL err_tag_second got data=%h err=%0b want 11 0", out_data, out_error);
        end
        flush = 1'b1;
        @(negedge clk) flush = 1'b0;
    endtask

    task automatic test_random;
        int rdy_pct;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            checks++;
            if (count !== 5'(q.size()) || out_valid !== (q.size() != 0) || full !== (q.size() == DEPTH) ||
                overflow !== m_ovf || (q.size() != 0 && {out_error, out_data} !== q[0])) begin
                errors++;
                $display("FAIL random cyc %0d got cnt=%0d v=%0b full=%0b ovf=%0b head=%h want cnt=%0d ovf=%0b head=%h",
                         c, count, out_valid, full, overflow, {out_error, out_data}, q.size(), m_ovf,
                         q.size() != 0 ? q[0] : 9'h0);
            end
            rdy_pct = (c / 300) % 3 == 0 ? 10 : ((c / 300) % 3 == 1 ? 50 : 90);
            if (!rx_done || $urandom_range(0, 2) == 0) begin
                rx_done  = $urandom_range(0, 1) == 1;
                rx_data  = 8'($urandom);
                rx_error = 1'($urandom);
            end
            out_ready = $urandom_range(0, 99) < rdy_pct;
            flush     = $urandom_range(0, 199) == 0;
            ovf_clr   = $urandom_range(0, 49) == 0;
        end
        flush = 1'b0; ovf_clr = 1'b0; out_ready = 1'b0; rx_done = 1'b1;
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 5; i++) push_byte(8'($urandom), 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 5'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got cnt=%0d v=%0b ovf=%0b want 0 0 0", count, out_valid, overflow);
        end
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (count !== 5'd0) begin
            errors++;
            $display("FAIL async_release got cnt=%0d want 0", count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop();
        test_hold_flush();
        test_err_tag();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
